// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// word geometry and the address helper used by the loader and its bench.
package im_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int          LANES     = 4;
    localparam int          LANE_W    = $clog2(LANES);
    localparam logic [15:0] ADDR_STEP = 16'd4;

    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return {addr[15:2], 2'b00};
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Load-request, byte-stream and SRAM write port bundle of the loader.
// master drives requests/bytes, slave is the loader itself.
interface im_loader_if;
    import im_loader_pkg::*;

    logic                 start;
    logic [15:0]          base_addr;
    logic [15:0]          byte_count;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic [LANES-1:0]     F_im_w_en;
    logic [15:0]          current_pc_15_0;
    logic [LANES*8-1:0]   im_write_data;
    logic                 busy;
    logic                 done;
    logic                 cpu_rst;

    modport master (
        output start, base_addr, byte_count, in_valid, in_data,
        input  in_ready, F_im_w_en, current_pc_15_0, im_write_data,
               busy, done, cpu_rst
    );

    modport slave (
        input  start, base_addr, byte_count, in_valid, in_data,
        output in_ready, F_im_w_en, current_pc_15_0, im_write_data,
               busy, done, cpu_rst
    );

endinterface

// File: rtl/im_byte_packer.sv
// Assembles incoming bytes little-endian into one SRAM word and tracks
// which lanes have been filled since the last clear.
module im_byte_packer
    import im_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic [7:0]           byte_in,
    output logic [LANES*8-1:0]   word,
    output logic [LANES-1:0]     mask,
    output logic                 last_lane
);

    logic [LANE_W-1:0] lane_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_reg <= '0;
        end else if (clear) begin
            lane_reg <= '0;
        end else if (push) begin
            lane_reg <= lane_reg + LANE_W'(1);
        end
    end

    // Cleared lanes read back as zero so a partial word carries no stale bytes.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] byte_reg;
            logic       valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (clear) begin
                    byte_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (push && lane_reg == LANE_W'(gi)) begin
                    byte_reg  <= byte_in;
                    valid_reg <= 1'b1;
                end
            end

            assign word[8*gi +: 8] = byte_reg;
            assign mask[gi]        = valid_reg;
        end
    endgenerate

    assign last_lane = (lane_reg == LANE_W'(LANES - 1));

endmodule

// File: rtl/im_loader.sv
// Streams a byte sequence into instruction SRAM one word at a time and
// holds the CPU in reset until the first load has finished.
module im_loader
    import im_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    im_loader_if.slave   bus
);

    state_t             state_reg;
    logic [15:0]        addr_reg;
    logic [15:0]        remaining_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               cpu_rst_reg;

    logic               accept_start;
    logic               xfer;
    logic               pack_clear;
    logic               last_lane;
    logic [LANES*8-1:0] word;
    logic [LANES-1:0]   mask;

    assign accept_start = (state_reg == ST_IDLE) && bus.start;
    assign xfer         = in_ready_reg && bus.in_valid;
    assign pack_clear   = accept_start || (state_reg == ST_WRITE);

    im_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .push      (xfer),
        .byte_in   (bus.in_data),
        .word      (word),
        .mask      (mask),
        .last_lane (last_lane)
    );

    // Handshake/status outputs are updated together with the state so they
    // always reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cpu_rst_reg   <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_reg      <= word_align(bus.base_addr);
                        remaining_reg <= bus.byte_count;
                        busy_reg      <= 1'b1;
                        if (bus.byte_count != '0) begin
                            state_reg    <= ST_COLLECT;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_DONE;
                            done_reg    <= 1'b1;
                            cpu_rst_reg <= 1'b0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (xfer) begin
                        remaining_reg <= remaining_reg - 16'd1;
                        if (last_lane || remaining_reg == 16'd1) begin
                            state_reg    <= ST_WRITE;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    addr_reg <= addr_reg + ADDR_STEP;
                    if (remaining_reg != '0) begin
                        state_reg    <= ST_COLLECT;
                        in_ready_reg <= 1'b1;
                    end else begin
                        state_reg   <= ST_DONE;
                        done_reg    <= 1'b1;
                        cpu_rst_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_reg;
    assign bus.F_im_w_en       = (state_reg == ST_WRITE) ? mask : '0;
    assign bus.current_pc_15_0 = addr_reg;
    assign bus.im_write_data   = word;
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.cpu_rst         = cpu_rst_reg;

endmodule
